// File: rtl/pipe_fifo_n.sv
// pipe_fifo_n: DEPTH-entry, WIDTH-bit FIFO between two pipeline stages.
// Optional fall-through bypass when empty. Flags for occupancy, almost-full and
// a sticky protocol error. Pointers wrap by explicit compare, so DEPTH does not
// need to be a power of two.
module pipe_fifo_n #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int FALLTHROUGH = 0,
  parameter int AF_THRESH   = DEPTH - 1,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             processed,
  output logic [CW-1:0]    count_o,
  output logic             almost_full_o,
  output logic             err_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             err_q;
  logic             empty, bypass, push, pop;

  // Handshake decode. A bypassed word never touches storage, so it is
  // neither a push nor a pop. ready_o depends only on registered count.
  always_comb begin
    empty   = (count == '0);
    ready_o = (count < DEPTH_C);
    valid_o = (FALLTHROUGH != 0) ? (!empty || valid_i) : !empty;
    bypass  = (FALLTHROUGH != 0) && empty && valid_i && processed;
    push    = valid_i && ready_o && !bypass;
    pop     = processed && valid_o && !bypass;
    if ((FALLTHROUGH != 0) && empty)
      data_o = data_i;
    else
      data_o = mem[rd_ptr];
  end

  assign count_o       = count;
  assign almost_full_o = (count >= AF_C);
  assign err_o         = err_q;

  // Storage write; flush discards the same-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  // Pointer and occupancy update; flush has top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error: consumer claimed a word that was not offered. Only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err_q <= 1'b0;
    else if (processed && !valid_o) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_pipe_fifo_n.sv
// Bench for pipe_fifo_n: a FALLTHROUGH=0 instance checked through a scoreboard
// of expected output words, plus a FALLTHROUGH=1 instance for the bypass path.
module tb_pipe_fifo_n;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance 0: DEPTH=4, FALLTHROUGH=0, AF_THRESH=3
  logic         flush0, valid0, proc0, ready0, vout0, af0, err0;
  logic [W-1:0] din0, dout0;
  logic [2:0]   cnt0;

  // instance 1: DEPTH=4, FALLTHROUGH=1
  logic         flush1, valid1, proc1, ready1, vout1, af1, err1;
  logic [W-1:0] din1, dout1;
  logic [2:0]   cnt1;

  pipe_fifo_n #(.WIDTH(W), .DEPTH(4), .FALLTHROUGH(0), .AF_THRESH(3)) u_dut0 (
    .clk(clk), .rst(rst), .flush_i(flush0), .data_i(din0), .valid_i(valid0),
    .ready_o(ready0), .data_o(dout0), .valid_o(vout0), .processed(proc0),
    .count_o(cnt0), .almost_full_o(af0), .err_o(err0));

  pipe_fifo_n #(.WIDTH(W), .DEPTH(4), .FALLTHROUGH(1), .AF_THRESH(3)) u_dut1 (
    .clk(clk), .rst(rst), .flush_i(flush1), .data_i(din1), .valid_i(valid1),
    .ready_o(ready1), .data_o(dout1), .valid_o(vout1), .processed(proc1),
    .count_o(cnt1), .almost_full_o(af1), .err_o(err1));

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted output word must match the next expected one.
  always @(negedge clk) begin
    if (!rst && !flush0 && vout0 && proc0) begin
      if (exp_q.size() == 0) chk("scb_underflow", {24'd0, dout0}, 32'hFFFF_FFFF);
      else chk("scb_data", {24'd0, dout0}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {flush0, valid0, proc0, flush1, valid1, proc1} = '0;
    din0 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready0, 1);
    chk("rst_valid", vout0, 0);
    chk("rst_data",  dout0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_af",    af0, 0);
    chk("rst_err",   err0, 0);
    chk("rst_cnt1",  cnt1, 0);
    @(posedge clk); #1 rst = 1'b0;

    // fill to full, almost_full at 3, 5th word held
    for (int i = 0; i < 4; i++) begin
      valid0 = 1'b1; din0 = W'(8'hA1 + i); exp_q.push_back(din0);
      @(negedge clk);
      chk("fill_count", cnt0, i);
      chk("fill_ready", ready0, 1);
      chk("fill_af",    af0, (i >= 3));
      tick();
    end
    din0 = 8'hA5;
    @(negedge clk);
    chk("full_count", cnt0, 4);
    chk("full_ready", ready0, 0);
    chk("full_af",    af0, 1);
    chk("full_valid", vout0, 1);
    tick();
    @(negedge clk);
    chk("held_count", cnt0, 4);
    tick();
    valid0 = 1'b0;

    // drain: ready rises only after the first pop
    proc0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_count", cnt0, 4 - k);
      chk("drain_ready", ready0, (k >= 1));
      tick();
    end
    proc0 = 1'b0;
    @(negedge clk);
    chk("drained_valid", vout0, 0);
    chk("drained_count", cnt0, 0);
    chk("drained_ready", ready0, 1);
    tick();

    // streaming with 2 pre-filled entries; pointers wrap repeatedly
    for (int i = 0; i < 2; i++) begin
      valid0 = 1'b1; din0 = W'(8'hB0 + i); exp_q.push_back(din0);
      tick();
    end
    proc0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din0 = W'(8'hB2 + i); exp_q.push_back(din0);
      @(negedge clk);
      chk("stream_count", cnt0, 2);
      tick();
    end
    valid0 = 1'b0;
    repeat (2) tick();
    proc0 = 1'b0;
    @(negedge clk);
    chk("stream_empty", cnt0, 0);
    chk("stream_qsize", exp_q.size(), 0);
    tick();

    // flush with same-cycle push and pop
    for (int i = 0; i < 3; i++) begin
      valid0 = 1'b1; din0 = W'(8'hD0 + i); exp_q.push_back(din0);
      tick();
    end
    flush0 = 1'b1; din0 = 8'hEE; proc0 = 1'b1;
    @(negedge clk);
    chk("flush_pre_count", cnt0, 3);
    chk("flush_pre_ready", ready0, 1);
    @(posedge clk);
    exp_q.delete();
    #1 flush0 = 1'b0; valid0 = 1'b0; proc0 = 1'b0;
    @(negedge clk);
    chk("flush_count", cnt0, 0);
    chk("flush_valid", vout0, 0);
    chk("flush_ready", ready0, 1);
    chk("flush_af",    af0, 0);
    tick();
    valid0 = 1'b1; din0 = 8'h77; exp_q.push_back(din0);
    tick();
    valid0 = 1'b0; proc0 = 1'b1;
    @(negedge clk);
    chk("post_flush_count", cnt0, 1);
    tick();
    proc0 = 1'b0;
    @(negedge clk);
    chk("post_flush_empty", cnt0, 0);
    chk("post_flush_qsize", exp_q.size(), 0);

    // protocol error: processed while empty
    tick();
    proc0 = 1'b1;
    @(negedge clk);
    chk("err_before", err0, 0);
    tick();
    proc0 = 1'b0;
    @(negedge clk);
    chk("err_set",   err0, 1);
    chk("err_count", cnt0, 0);
    chk("err_valid", vout0, 0);
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    @(negedge clk);
    chk("err_after_flush", err0, 1);

    // asynchronous reset mid-stream
    tick();
    valid0 = 1'b1; din0 = 8'h31; exp_q.push_back(din0);
    tick();
    din0 = 8'h32; exp_q.push_back(din0);
    tick();
    din0 = 8'h33;
    #1 chk("arst_pre_count", cnt0, 2);
    rst = 1'b1;
    #1;
    chk("arst_count", cnt0, 0);
    chk("arst_valid", vout0, 0);
    chk("arst_ready", ready0, 1);
    chk("arst_data",  dout0, 0);
    chk("arst_af",    af0, 0);
    chk("arst_err",   err0, 0);
    exp_q.delete();
    valid0 = 1'b0;
    tick();
    rst = 1'b0;

    // fall-through instance: bypass, then zero-latency push
    tick();
    valid1 = 1'b1; din1 = 8'h55; proc1 = 1'b1;
    #1;
    chk("ft_byp_valid", vout1, 1);
    chk("ft_byp_data",  dout1, 8'h55);
    chk("ft_byp_count", cnt1, 0);
    tick();
    chk("ft_byp_nostore", cnt1, 0);
    proc1 = 1'b0; din1 = 8'h66;
    #1;
    chk("ft_push_valid", vout1, 1);
    chk("ft_push_data",  dout1, 8'h66);
    tick();
    valid1 = 1'b0; din1 = 8'h00;
    #1;
    chk("ft_stored_count", cnt1, 1);
    chk("ft_stored_data",  dout1, 8'h66);
    proc1 = 1'b1;
    tick();
    proc1 = 1'b0;
    #1;
    chk("ft_pop_count", cnt1, 0);
    chk("ft_pop_valid", vout1, 0);
    chk("ft_err",       err1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipe_fifo_n.md
Name: pipe_fifo_n

Overview:
- Parametrised successor to the single-entry pipeline buffer: a DEPTH-entry, WIDTH-bit FIFO between two pipeline stages.
- Uses the same valid_i/ready_o upstream handshake and valid_o/processed downstream handshake.
- Adds multi-entry buffering, an optional fall-through (bypass) mode, an occupancy count, an almost-full flag, a synchronous flush and a sticky protocol-error flag.
- Sits between producer and consumer stages to absorb stalls without a bubble per transfer.

Parameters:
- WIDTH, 32, data width in bits (>=1).
- DEPTH, 4, number of storage entries (>=1; need not be a power of 2).
- FALLTHROUGH, 0, 1 = when empty, input data is presented on data_o in the same cycle (zero latency); 0 = minimum latency of 1 cycle.
- AF_THRESH, DEPTH-1, almost_full_o asserts when count_o >= AF_THRESH (1..DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous flush, discards all entries.
- data_i  in  WIDTH  data from previous stage.
- valid_i  in  1  data_i valid.
- ready_o  out  1  FIFO can accept data this cycle.
- data_o  out  WIDTH  head entry for next stage.
- valid_o  out  1  data_o valid.
- processed  in  1  next stage consumes head this cycle.
- count_o  out  $clog2(DEPTH+1)  stored-entry count.
- almost_full_o  out  1  count_o >= AF_THRESH.
- err_o  out  1  sticky: processed seen while valid_o low.

Behaviour:
- Reset (async assert, released synchronously by the surrounding reset logic):
  - wr_ptr, rd_ptr, count = 0; all storage = 0; err_o = 0.
  - Outputs: ready_o=1, valid_o=0, data_o=0, count_o=0, almost_full_o=0 (AF_THRESH>=1).
  - Reset mid-transfer drops all data immediately, without waiting for a clock edge.
- Push = valid_i & ready_o. Pop = processed & valid_o. Both take effect at the rising edge.
- ready_o = (count < DEPTH). It is purely state-based, with no combinational path from processed. When full, a same-cycle pop does not enable a push; ready_o rises the cycle after the pop.
- valid_o:
  - FALLTHROUGH=0: valid_o = (count != 0).
  - FALLTHROUGH=1: valid_o = (count != 0) | valid_i.
- data_o = mem[rd_ptr] when count != 0. When count == 0 and FALLTHROUGH=1, data_o = data_i (combinational bypass). When count == 0 and FALLTHROUGH=0, data_o = mem[rd_ptr] (stale; value is don't-care, consumers must qualify with valid_o).
- Bypass: with FALLTHROUGH=1, count==0, valid_i=1 and processed=1, the word passes straight through. It is not written; pointers and count are unchanged.
- Push writes mem[wr_ptr] <= data_i and advances wr_ptr. Pop advances rd_ptr. Pointers wrap from DEPTH-1 to 0, with an explicit compare (no power-of-2 assumption).
- count update: +1 on push only, -1 on pop only, unchanged on push+pop (or on bypass). count never exceeds DEPTH and never underflows.
- FIFO order is strict; no reordering or duplication.
- Latency, FALLTHROUGH=0: a word pushed at edge N is visible on data_o/valid_o after edge N if the FIFO was empty. FALLTHROUGH=1: visible in cycle N itself.
- almost_full_o = (count >= AF_THRESH), registered-state-derived.
- flush_i has highest synchronous priority:
  - Next edge: count, wr_ptr, rd_ptr = 0; a same-cycle push or pop is ignored.
  - ready_o stays per the current count during the flush cycle; the upstream word is lost if accepted.
  - err_o is not cleared by flush.
- err_o:
  - Sets at the edge where processed=1 and valid_o=0. Stays set until rst.
  - Such a processed has no other effect.
- data_i is ignored when valid_i=0. valid_i high while ready_o=0 is legal (producer holds); no error.

Test Plan:
- DEPTH=4, FALLTHROUGH=0, processed=0: push 0xA1,0xA2,0xA3,0xA4 on consecutive cycles -> count_o 1,2,3,4. almost_full_o rises when count_o=3. ready_o=0 after 4th edge. 5th valid_i with 0xA5 is held, not stored.
- From full, assert processed for 4 cycles with valid_i=0 -> data_o 0xA1..0xA4 in order, count_o 3,2,1,0, valid_o falls after 4th pop. ready_o rises one cycle after the first pop.
- Continuous streaming, valid_i=processed=1 for 20 cycles with incrementing data, FIFO pre-filled with 2 -> count_o constant 2, output sequence equals input sequence, no loss. Include pointer wrap past DEPTH-1.
- FALLTHROUGH=1, empty, valid_i=1, data_i=0x55, processed=1 same cycle -> valid_o=1, data_o=0x55 combinationally, count_o stays 0, no entry stored.
- FIFO holding 3 entries, flush_i=1 with valid_i=1 and processed=1 -> next cycle count_o=0, valid_o=0, ready_o=1. The pushed word never appears.
- processed=1 while empty -> err_o=1 from next edge, count_o stays 0, err_o survives flush. Assert rst asynchronously mid-stream -> outputs return to reset values before the next clock edge.
